alu_sequencer: RTL and testbench

Issue-side controller for the 8-bit ALU. It accepts instruction words from a host through a valid/ready port and buffers them in a small FIFO. For each instruction it reads operands from a 4×8 register file and drives the ALU's `opcode`/`operand_A`/`operand_B`/`input_ready`/`enable`/`carry_in`/`borrow_in` inputs. It waits for `result_ready`, then writes `result_out` back to the register file and reports the ALU flags to the host.

---
 rtl/alu_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue-side controller for the 8-bit ALU: buffers host instructions, reads operands
// from a 4x8 register file, issues them to the ALU and writes each result back.
module alu_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned NUM_OPS    = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [10:0]       instr_word,
    output logic              instr_ready,
    input  logic              reg_wr_en,
    input  logic [1:0]        reg_wr_addr,
    input  logic [7:0]        reg_wr_data,
    input  logic [1:0]        reg_rd_addr,
    output logic [7:0]        reg_rd_data,
    output logic [4:0]        opcode,
    output logic signed [7:0] operand_A,
    output logic signed [7:0] operand_B,
    output logic              input_ready,
    output logic              enable,
    output logic              carry_in,
    output logic              borrow_in,
    input  logic [7:0]        result_out,
    input  logic              result_ready,
    input  logic              carry_out,
    input  logic              borrow_out,
    input  logic              zero,
    input  logic              negative,
    input  logic              overflow,
    output logic              done,
    output logic [7:0]        done_result,
    output logic [4:0]        done_flags,
    output logic              err_illegal,
    output logic              err_timeout,
    input  logic              err_clr,
    output logic              busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [10:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [TMO_W-1:0] wait_cnt;
    logic [7:0]       regs [4];
    logic [1:0]       dst_q;
    logic [10:0]      head;
    logic             head_legal;
    logic             push;
    logic             pop;
    logic             issue;
    logic             illegal;
    logic             writeback;
    logic             timed_out;

    assign head        = fifo_mem[rd_ptr];
    assign head_legal  = 32'(head[10:6]) < NUM_OPS;
    assign push        = instr_valid & instr_ready;
    assign pop         = (state == S_IDLE) && (count != '0);
    assign reg_rd_data = regs[reg_rd_addr];

    // Occupancy after this edge; pop and push never conflict because full blocks push.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Next-state and per-edge event decode.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        illegal    = 1'b0;
        writeback  = 1'b0;
        timed_out  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    if (head_legal) begin
                        issue      = 1'b1;
                        state_next = S_ISSUE;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (result_ready) begin
                    writeback  = 1'b1;
                    state_next = S_IDLE;
                end else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= instr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
        end
    end

    // Writeback is assigned last so it overrides a host write to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (reg_wr_en) begin
                regs[reg_wr_addr] <= reg_wr_data;
            end
            if (writeback) begin
                regs[dst_q] <= result_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            enable      <= 1'b0;
            input_ready <= 1'b0;
            opcode      <= '0;
            operand_A   <= '0;
            operand_B   <= '0;
            dst_q       <= '0;
            done        <= 1'b0;
            done_result <= '0;
            done_flags  <= '0;
            carry_in    <= 1'b0;
            borrow_in   <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            instr_ready <= (count_next != CNT_W'(FIFO_DEPTH));
            busy        <= (state_next != S_IDLE) || (count_next != '0);
            enable      <= (state_next != S_IDLE);
            input_ready <= issue;
            done        <= writeback;
            if (issue) begin
                opcode    <= head[10:6];
                operand_A <= regs[head[3:2]];
                operand_B <= regs[head[1:0]];
                dst_q     <= head[5:4];
            end
            if (writeback) begin
                done_result <= result_out;
                done_flags  <= {overflow, negative, zero, borrow_out, carry_out};
                carry_in    <= carry_out;
                borrow_in   <= borrow_out;
            end
            err_illegal <= (err_illegal & ~err_clr) | illegal;
            err_timeout <= (err_timeout & ~err_clr) | timed_out;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-level model compared every cycle,
// a scripted fake ALU, and directed scenarios with hand-computed expectations.
module tb_alu_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;
    localparam int NUM_OPS    = 20;
    localparam int PH_IDLE    = 0;
    localparam int PH_ISSUE   = 1;
    localparam int PH_WAIT    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [10:0] instr_word;
    logic        instr_ready;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic [1:0]  reg_rd_addr;
    logic [7:0]  reg_rd_data;
    logic [4:0]  opcode;
    logic [7:0]  operand_A;
    logic [7:0]  operand_B;
    logic        input_ready;
    logic        enable;
    logic        carry_in;
    logic        borrow_in;
    logic [7:0]  result_out;
    logic        result_ready;
    logic        carry_out;
    logic        borrow_out;
    logic        zero;
    logic        negative;
    logic        overflow;
    logic        done;
    logic [7:0]  done_result;
    logic [4:0]  done_flags;
    logic        err_illegal;
    logic        err_timeout;
    logic        err_clr;
    logic        busy;

    alu_sequencer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT   (TIMEOUT),
        .NUM_OPS   (NUM_OPS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_word  (instr_word),
        .instr_ready (instr_ready),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .opcode      (opcode),
        .operand_A   (operand_A),
        .operand_B   (operand_B),
        .input_ready (input_ready),
        .enable      (enable),
        .carry_in    (carry_in),
        .borrow_in   (borrow_in),
        .result_out  (result_out),
        .result_ready(result_ready),
        .carry_out   (carry_out),
        .borrow_out  (borrow_out),
        .zero        (zero),
        .negative    (negative),
        .overflow    (overflow),
        .done        (done),
        .done_result (done_result),
        .done_flags  (done_flags),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .err_clr     (err_clr),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int ir_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: instruction queue plus the phase of the op in flight.
    logic [10:0] mq[$];
    int          m_phase;
    int          m_wait;
    logic [7:0]  m_regs [4];
    logic [1:0]  m_dst;
    logic        m_ready, m_busy, m_en, m_ir, m_cin, m_bin, m_done, m_eill, m_etmo;
    logic [4:0]  m_opcode, m_dflags;
    logic [7:0]  m_a, m_b, m_dres;

    task automatic model_reset();
        mq.delete();
        m_phase = PH_IDLE;
        m_wait  = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
        m_dst = 2'd0; m_ready = 1'b1; m_busy = 1'b0; m_en = 1'b0; m_ir = 1'b0;
        m_cin = 1'b0; m_bin = 1'b0; m_done = 1'b0; m_eill = 1'b0; m_etmo = 1'b0;
        m_opcode = 5'd0; m_dflags = 5'd0; m_a = 8'd0; m_b = 8'd0; m_dres = 8'd0;
    endtask

    task automatic model_step();
        logic [10:0] w;
        logic        accept, ill, tmo, wb;
        accept = instr_valid && m_ready;
        ill = 1'b0; tmo = 1'b0; wb = 1'b0;
        m_done = 1'b0;
        m_ir   = 1'b0;
        if (m_phase == PH_IDLE) begin
            if (mq.size() > 0) begin
                w = mq.pop_front();
                if (int'(w[10:6]) >= NUM_OPS) begin
                    ill = 1'b1;
                end else begin
                    m_opcode = w[10:6];
                    m_a      = m_regs[w[3:2]];
                    m_b      = m_regs[w[1:0]];
                    m_dst    = w[5:4];
                    m_ir     = 1'b1;
                    m_phase  = PH_ISSUE;
                end
            end
        end else if (m_phase == PH_ISSUE) begin
            m_phase = PH_WAIT;
            m_wait  = 0;
        end else begin
            m_wait++;
            if (result_ready) begin
                wb = 1'b1;
                m_phase = PH_IDLE;
            end else if (m_wait == TIMEOUT) begin
                tmo = 1'b1;
                m_phase = PH_IDLE;
            end
        end
        if (reg_wr_en) m_regs[reg_wr_addr] = reg_wr_data;
        if (wb) begin
            m_regs[m_dst] = result_out;
            m_done  = 1'b1;
            m_dres  = result_out;
            m_dflags = {overflow, negative, zero, borrow_out, carry_out};
            m_cin   = carry_out;
            m_bin   = borrow_out;
        end
        m_eill = (m_eill && !err_clr) || ill;
        m_etmo = (m_etmo && !err_clr) || tmo;
        if (accept) mq.push_back(instr_word);
        m_ready = mq.size() < FIFO_DEPTH;
        m_busy  = (m_phase != PH_IDLE) || (mq.size() != 0);
        m_en    = (m_phase != PH_IDLE);
    endtask

    task automatic compare_all();
        chk("instr_ready", 32'(instr_ready), 32'(m_ready));
        chk("busy",        32'(busy),        32'(m_busy));
        chk("enable",      32'(enable),      32'(m_en));
        chk("input_ready", 32'(input_ready), 32'(m_ir));
        chk("opcode",      32'(opcode),      32'(m_opcode));
        chk("operand_A",   32'(operand_A),   32'(m_a));
        chk("operand_B",   32'(operand_B),   32'(m_b));
        chk("carry_in",    32'(carry_in),    32'(m_cin));
        chk("borrow_in",   32'(borrow_in),   32'(m_bin));
        chk("done",        32'(done),        32'(m_done));
        chk("done_result", 32'(done_result), 32'(m_dres));
        chk("done_flags",  32'(done_flags),  32'(m_dflags));
        chk("err_illegal", 32'(err_illegal), 32'(m_eill));
        chk("err_timeout", 32'(err_timeout), 32'(m_etmo));
        chk("reg_rd_data", 32'(reg_rd_data), 32'(m_regs[reg_rd_addr]));
    endtask

    // Model advance and compare, just after each rising edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n) model_step();
            else model_reset();
            #1;
            if (input_ready) ir_cnt++;
            compare_all();
        end
    end

    // Fake ALU: result = A + B + opcode, returned alu_lat cycles after the issue strobe.
    logic alu_stall = 1'b0;
    logic alu_force = 1'b0;
    logic alu_cout  = 1'b0;
    logic alu_bout  = 1'b0;
    logic alu_ovf   = 1'b0;
    int   alu_lat   = 2;

    initial begin
        int         cnt;
        logic [7:0] res;
        cnt = 0;
        result_ready = 1'b0; result_out = 8'd0; carry_out = 1'b0; borrow_out = 1'b0;
        zero = 1'b0; negative = 1'b0; overflow = 1'b0;
        forever begin
            @(negedge clk);
            result_ready = alu_force;
            if (!rst_n) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        res          = 8'(operand_A + operand_B + 8'(opcode));
                        result_out   = res;
                        result_ready = 1'b1;
                        carry_out    = alu_cout;
                        borrow_out   = alu_bout;
                        zero         = (res == 8'd0);
                        negative     = res[7];
                        overflow     = alu_ovf;
                    end
                end
                if (input_ready && !alu_stall) cnt = alu_lat;
            end
        end
    end

    function automatic logic [10:0] iw(input int op, input int d, input int a, input int b);
        return {5'(op), 2'(d), 2'(a), 2'(b)};
    endfunction

    // All host tasks are entered and left on a falling edge.
    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
        @(negedge clk);
        reg_wr_en = 1'b0;
    endtask

    task automatic push(input logic [10:0] w);
        int t;
        instr_valid = 1'b1;
        instr_word  = w;
        t = 0;
        while (!instr_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("push_accepted", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_ir();
        int t;
        t = 0;
        while (!input_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("issue_seen", 32'(input_ready), 32'd1);
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        reg_rd_addr = a;
        #1;
        chk(name, 32'(reg_rd_data), 32'(exp));
    endtask

    initial begin
        int n;
        int ir0;
        int t;
        rst_n = 1'b0; instr_valid = 1'b0; instr_word = 11'd0; reg_wr_en = 1'b0;
        reg_wr_addr = 2'd0; reg_wr_data = 8'd0; reg_rd_addr = 2'd0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add: r0=5, r1=3, r2 <- r0 + r1
        wr_reg(2'd0, 8'd5);
        wr_reg(2'd1, 8'd3);
        alu_lat = 2;
        push(iw(0, 2, 0, 1));
        @(negedge clk);
        chk("t1_input_ready", 32'(input_ready), 32'd1);
        chk("t1_operand_A", 32'(operand_A), 32'd5);
        chk("t1_operand_B", 32'(operand_B), 32'd3);
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_done_result", 32'(done_result), 32'd8);
        wait_idle();
        read_chk("t1_r2", 2'd2, 8'd8);

        // Back-to-back fill while the ALU is slow; results depend on FIFO order
        alu_lat = 10;
        push(iw(1, 3, 0, 1));
        @(negedge clk);
        push(iw(2, 0, 2, 3));
        push(iw(3, 1, 0, 0));
        push(iw(4, 2, 1, 3));
        push(iw(5, 3, 2, 0));
        chk("t2_full_not_ready", 32'(instr_ready), 32'd0);
        push(iw(6, 0, 3, 1));
        wait_idle();
        read_chk("t2_r0", 2'd0, 8'd125);
        read_chk("t2_r1", 2'd1, 8'd41);
        read_chk("t2_r2", 2'd2, 8'd54);
        read_chk("t2_r3", 2'd3, 8'd78);

        // Illegal opcode is dropped; the following legal op still issues
        alu_lat = 1;
        ir0 = ir_cnt;
        push(iw(25, 0, 0, 0));
        push(iw(0, 1, 2, 3));
        wait_idle();
        chk("t3_err_illegal", 32'(err_illegal), 32'd1);
        chk("t3_issue_count", 32'(ir_cnt - ir0), 32'd1);
        read_chk("t3_r1", 2'd1, 8'd132);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_err_cleared", 32'(err_illegal), 32'd0);
        err_clr = 1'b1;
        push(iw(25, 1, 1, 1));
        @(negedge clk);
        chk("t3_set_beats_clear", 32'(err_illegal), 32'd1);
        err_clr = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Timeout: first op abandoned after 16 WAIT edges, queued op then completes
        alu_stall = 1'b1;
        push(iw(0, 2, 0, 1));
        push(iw(7, 3, 1, 1));
        chk("t4_issue", 32'(input_ready), 32'd1);
        n = 0;
        while (!err_timeout && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 2) alu_stall = 1'b0;
        end
        chk("t4_timeout_cycles", 32'(n), 32'd17);
        wait_idle();
        chk("t4_err_timeout", 32'(err_timeout), 32'd1);
        read_chk("t4_r2_unchanged", 2'd2, 8'd54);
        read_chk("t4_r3", 2'd3, 8'd15);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // Carry/borrow from one op are presented with the next
        alu_cout = 1'b1; alu_bout = 1'b1; alu_ovf = 1'b1;
        push(iw(0, 0, 1, 2));
        wait_idle();
        chk("t5_carry_in", 32'(carry_in), 32'd1);
        chk("t5_borrow_in", 32'(borrow_in), 32'd1);
        chk("t5_done_flags", 32'(done_flags), 32'd27);
        read_chk("t5_r0", 2'd0, 8'd186);
        alu_cout = 1'b0; alu_bout = 1'b0; alu_ovf = 1'b0;
        push(iw(1, 1, 0, 0));
        wait_ir();
        chk("t5_next_carry_in", 32'(carry_in), 32'd1);
        chk("t5_next_borrow_in", 32'(borrow_in), 32'd1);
        wait_idle();
        chk("t5_carry_cleared", 32'(carry_in), 32'd0);

        // Reset in WAIT with two ops queued, then a stale result_ready
        alu_stall = 1'b1;
        push(iw(0, 3, 0, 1));
        push(iw(1, 2, 0, 1));
        push(iw(2, 1, 0, 1));
        repeat (3) @(negedge clk);
        reg_rd_addr = 2'd0;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_instr_ready", 32'(instr_ready), 32'd1);
        chk("t6_enable", 32'(enable), 32'd0);
        chk("t6_r0_cleared", 32'(reg_rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_force = 1'b1;
        repeat (2) @(negedge clk);
        alu_force = 1'b0;
        chk("t6_no_done", 32'(done), 32'd0);
        chk("t6_still_idle", 32'(busy), 32'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
